// File: rtl/light_hash_param.sv
// Framed printable-ASCII hash core: absorbs payload bytes into an N-byte state through
// ROUNDS S-box rounds per byte and holds the digest of the last completed frame.
module light_hash_param #(
    parameter int unsigned             N_BLOCKS   = 8,
    parameter int unsigned             ROUNDS     = 32,
    parameter int unsigned             MAX_LEN    = 1024,
    parameter logic [8*N_BLOCKS-1:0]   IV         = '0,
    parameter logic [7:0]              START_CHAR = 8'hFF,
    parameter logic [7:0]              END_CHAR   = 8'h00
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              msg_byte_i,
    input  logic                    msg_valid_i,
    output logic                    msg_ready_o,
    output logic [8*N_BLOCKS-1:0]   digest_o,
    output logic                    digest_valid_o,
    output logic                    err_invalid_byte_o,
    output logic                    err_overflow_o,
    output logic                    busy_o
);

    localparam int unsigned LenW = $clog2(MAX_LEN + 1);
    localparam int unsigned DigW = 8 * N_BLOCKS;

    typedef enum logic [1:0] {StIdle, StAbsorb, StRound} state_e;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned sh);
        logic [15:0] w;
        w = {x, x} << sh;
        return w[15:8];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aes128_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        // x^254 is the GF(2^8) inverse (and maps 0 to 0), followed by the AES affine map
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        h_q [N_BLOCKS];
    logic [7:0]        h_d [N_BLOCKS];
    logic [7:0]        h_iv [N_BLOCKS];
    logic [7:0]        h_round [N_BLOCKS];
    logic [DigW-1:0]   h_flat;
    logic [7:0]        m_q, m_d;
    logic [7:0]        round_q, round_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [DigW-1:0]   digest_q, digest_d;
    logic              dv_q, dv_d;
    logic              inv_q, inv_d;
    logic              ovf_q, ovf_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic              legal;

    always_comb begin
        for (int j = 0; j < N_BLOCKS; j++) begin
            h_iv[j]                     = IV[DigW-1-8*j -: 8];
            h_round[j]                  = aes128_sbox(rotl8(h_q[(j + 2) % N_BLOCKS] ^ m_q, j % 8));
            h_flat[DigW-1-8*j -: 8]     = h_q[j];
        end
    end

    assign accept = msg_valid_i && ready_q;
    assign legal  = (msg_byte_i >= 8'h20) && (msg_byte_i <= 8'h7E);

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        m_d      = m_q;
        round_d  = round_q;
        len_d    = len_q;
        digest_d = digest_q;
        dv_d     = dv_q;
        inv_d    = inv_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (accept && msg_byte_i == START_CHAR) begin
                    h_d     = h_iv;
                    len_d   = '0;
                    inv_d   = 1'b0;
                    ovf_d   = 1'b0;
                    dv_d    = 1'b0;
                    state_d = StAbsorb;
                end
            end
            StAbsorb: begin
                if (accept) begin
                    // Markers are decoded ahead of the printable-range check
                    if (msg_byte_i == END_CHAR) begin
                        digest_d = h_flat;
                        dv_d     = 1'b1;
                        state_d  = StIdle;
                    end else if (msg_byte_i == START_CHAR) begin
                        h_d   = h_iv;
                        len_d = '0;
                    end else if (legal) begin
                        if (len_q == LenW'(MAX_LEN)) begin
                            ovf_d   = 1'b1;
                            state_d = StIdle;
                        end else begin
                            m_d     = msg_byte_i;
                            round_d = 8'd0;
                            len_d   = len_q + LenW'(1);
                            state_d = StRound;
                        end
                    end else begin
                        inv_d   = 1'b1;
                        h_d     = h_iv;
                        state_d = StIdle;
                    end
                end
            end
            StRound: begin
                h_d     = h_round;
                round_d = round_q + 8'd1;
                if (round_q == 8'(ROUNDS - 1)) state_d = StAbsorb;
            end
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle) || (state_d == StAbsorb);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            h_q      <= h_iv;
            m_q      <= 8'h00;
            round_q  <= 8'd0;
            len_q    <= '0;
            digest_q <= '0;
            dv_q     <= 1'b0;
            inv_q    <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            m_q      <= m_d;
            round_q  <= round_d;
            len_q    <= len_d;
            digest_q <= digest_d;
            dv_q     <= dv_d;
            inv_q    <= inv_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
        end
    end

    assign msg_ready_o        = ready_q;
    assign digest_o           = digest_q;
    assign digest_valid_o     = dv_q;
    assign err_invalid_byte_o = inv_q;
    assign err_overflow_o     = ovf_q;
    assign busy_o             = (state_q != StIdle);

endmodule
